// File: rtl/sumador_acumulador.sv
// -----------------------------------------------------------------------------
// sumador_acumulador
//
// Purpose:
//    Parametrised add / subtract / accumulate unit for unsigned operands. One
//    operation is accepted at a time under a valid/ready handshake. It is
//    computed in a single cycle, and the registered result is then held until
//    the consumer (normally the hexadecimal display decoder) takes it.
//
// Parameters:
//    ANCHO       operand width in bits (>= 1)
//    ANCHO_SUMA  result / accumulator width (must be >= ANCHO+1)
//    SATURAR     accumulate-overflow policy: 1 clamps to all-ones, 0 wraps
//
// Ports:
//    clk             rising-edge clock
//    reset           synchronous, active-high reset
//    entrada_valida  operands and modo are valid
//    entrada_lista   block can accept an operation
//    binario0        operand A, unsigned
//    binario1        operand B, unsigned
//    modo            00 add pair, 01 accumulate, 10 subtract, 11 clear acc
//    salida_valida   suma / desborde hold a result
//    salida_lista    consumer accepts the result
//    suma            registered result
//    desborde        overflow (accumulate) or borrow (subtract) flag
//    operaciones     count of accepted operations, wraps 255 -> 0
//
// Timing:
//    ESPERA --accept--> CALCULO --1 edge--> ENTREGA --salida_lista--> ESPERA.
//    With salida_lista held high, a new operation can be accepted every
//    third cycle.
// -----------------------------------------------------------------------------
module sumador_acumulador #(
   parameter int ANCHO      = 4,
   parameter int ANCHO_SUMA = 8,
   parameter bit SATURAR    = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  entrada_valida,
   output logic                  entrada_lista,
   input  logic [ANCHO-1:0]      binario0,
   input  logic [ANCHO-1:0]      binario1,
   input  logic [1:0]            modo,
   output logic                  salida_valida,
   input  logic                  salida_lista,
   output logic [ANCHO_SUMA-1:0] suma,
   output logic                  desborde,
   output logic [7:0]            operaciones
);

   // One spare bit above the result width. It catches the accumulator carry
   // and doubles as the sign bit of the subtraction.
   localparam int W_EXT = ANCHO_SUMA + 1;

   // FSM encoding
   localparam logic [1:0] ESPERA  = 2'd0;
   localparam logic [1:0] CALCULO = 2'd1;
   localparam logic [1:0] ENTREGA = 2'd2;

   // Operation select codes
   localparam logic [1:0] MODO_SUMA  = 2'b00;
   localparam logic [1:0] MODO_ACUM  = 2'b01;
   localparam logic [1:0] MODO_RESTA = 2'b10;
   localparam logic [1:0] MODO_BORRA = 2'b11;

   // --------------------------------------------------------------------------
   // State and datapath registers
   // --------------------------------------------------------------------------
   logic [1:0]            r_estado;
   logic [ANCHO-1:0]      r_a;
   logic [ANCHO-1:0]      r_b;
   logic [1:0]            r_modo;
   logic [ANCHO_SUMA-1:0] r_acc;
   logic [ANCHO_SUMA-1:0] r_suma;
   logic                  r_desborde;
   logic                  r_salida_valida;
   logic                  r_entrada_lista;
   logic [7:0]            r_operaciones;

   // --------------------------------------------------------------------------
   // Combinational arithmetic on the latched operands
   // --------------------------------------------------------------------------
   logic [W_EXT-1:0]      w_a_ext;
   logic [W_EXT-1:0]      w_b_ext;
   logic [ANCHO_SUMA-1:0] w_sum_par;
   logic [W_EXT-1:0]      w_acc_tmp;
   logic                  w_acc_carry;
   logic [ANCHO_SUMA-1:0] w_acc_desbordado;
   logic [W_EXT-1:0]      w_dif;

   logic [ANCHO_SUMA-1:0] w_suma_nueva;
   logic                  w_desborde_nuevo;
   logic [ANCHO_SUMA-1:0] w_acc_nuevo;
   logic                  w_acc_escribe;

   assign w_a_ext = {{(W_EXT - ANCHO){1'b0}}, r_a};
   assign w_b_ext = {{(W_EXT - ANCHO){1'b0}}, r_b};

   // A + B cannot exceed ANCHO_SUMA bits because ANCHO_SUMA >= ANCHO+1.
   assign w_sum_par = w_a_ext[ANCHO_SUMA-1:0] + w_b_ext[ANCHO_SUMA-1:0];

   // The accumulate carry out of the result width is the overflow indication.
   assign w_acc_tmp   = {1'b0, r_acc} + w_a_ext;
   assign w_acc_carry = w_acc_tmp[ANCHO_SUMA];

   // Both operands are below 2^ANCHO <= 2^(ANCHO_SUMA-1), so the top bit of
   // the extended difference is set exactly when B > A (a borrow occurred).
   assign w_dif = w_a_ext - w_b_ext;

   // Value the accumulator takes when the carry fires.
   generate
      if (SATURAR) begin : g_satura
         assign w_acc_desbordado = {ANCHO_SUMA{1'b1}};
      end else begin : g_envuelve
         assign w_acc_desbordado = w_acc_tmp[ANCHO_SUMA-1:0];
      end
   endgenerate

   always_comb begin
      w_suma_nueva     = '0;
      w_desborde_nuevo = 1'b0;
      w_acc_nuevo      = r_acc;
      w_acc_escribe    = 1'b0;
      case (r_modo)
         MODO_SUMA: begin
            w_suma_nueva = w_sum_par;
         end
         MODO_ACUM: begin
            w_acc_escribe    = 1'b1;
            w_desborde_nuevo = w_acc_carry;
            w_acc_nuevo      = w_acc_carry ? w_acc_desbordado
                                           : w_acc_tmp[ANCHO_SUMA-1:0];
            // The result shown is the accumulator after the update.
            w_suma_nueva     = w_acc_nuevo;
         end
         MODO_RESTA: begin
            w_suma_nueva     = w_dif[ANCHO_SUMA-1:0];
            w_desborde_nuevo = w_dif[ANCHO_SUMA];
         end
         MODO_BORRA: begin
            w_acc_escribe = 1'b1;
            w_acc_nuevo   = '0;
         end
         default: begin
            w_suma_nueva = '0;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Control FSM and result registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         // Discards any in-flight operation. No result is delivered.
         r_estado        <= ESPERA;
         r_a             <= '0;
         r_b             <= '0;
         r_modo          <= MODO_SUMA;
         r_acc           <= '0;
         r_suma          <= '0;
         r_desborde      <= 1'b0;
         r_salida_valida <= 1'b0;
         r_entrada_lista <= 1'b1;
         r_operaciones   <= 8'd0;
      end else begin
         case (r_estado)
            ESPERA: begin
               // Operands are captured only here. Later input changes are ignored.
               if (entrada_valida) begin
                  r_a             <= binario0;
                  r_b             <= binario1;
                  r_modo          <= modo;
                  r_operaciones   <= r_operaciones + 8'd1;
                  r_entrada_lista <= 1'b0;
                  r_estado        <= CALCULO;
               end
            end
            CALCULO: begin
               r_suma          <= w_suma_nueva;
               r_desborde      <= w_desborde_nuevo;
               if (w_acc_escribe) begin
                  r_acc <= w_acc_nuevo;
               end
               r_salida_valida <= 1'b1;
               r_estado        <= ENTREGA;
            end
            ENTREGA: begin
               // Hold the result until the consumer takes it. Ready comes
               // back only after the handshake, so a held entrada_valida is
               // accepted one edge later at the earliest.
               if (salida_lista) begin
                  r_salida_valida <= 1'b0;
                  r_entrada_lista <= 1'b1;
                  r_estado        <= ESPERA;
               end
            end
            default: begin
               // Unreachable encoding: fall back to idle without a result.
               r_salida_valida <= 1'b0;
               r_entrada_lista <= 1'b1;
               r_estado        <= ESPERA;
            end
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // Outputs (all straight from registers)
   // --------------------------------------------------------------------------
   assign entrada_lista = r_entrada_lista;
   assign salida_valida = r_salida_valida;
   assign suma          = r_suma;
   assign desborde      = r_desborde;
   assign operaciones   = r_operaciones;

endmodule

// File: tb/tb_sumador_acumulador.sv
// -----------------------------------------------------------------------------
// tb_sumador_acumulador
//
// Three instances share one set of stimulus:
//    dut0  ANCHO=4, ANCHO_SUMA=8, wrap
//    dut1  ANCHO=4, ANCHO_SUMA=8, saturate
//    dut2  ANCHO=8, ANCHO_SUMA=9, wrap (width sweep)
// dut0 is the handshake reference. All three share the same latency, so they
// stay in lock-step.
// -----------------------------------------------------------------------------
module tb_sumador_acumulador;

   logic       clk = 1'b0;
   logic       reset;
   logic       ev;
   logic       sl;
   logic [1:0] modo;
   logic [7:0] a8;
   logic [7:0] b8;

   logic       el0, sv0, ds0;
   logic [7:0] s0, op0;
   logic       el1, sv1, ds1;
   logic [7:0] s1, op1;
   logic       el2, sv2, ds2;
   logic [8:0] s2;
   logic [7:0] op2;

   int errors = 0;
   int checks = 0;
   int exp_ops = 0;

   always #5 clk = ~clk;

   sumador_acumulador #(.ANCHO(4), .ANCHO_SUMA(8), .SATURAR(1'b0)) dut0 (
      .clk(clk), .reset(reset), .entrada_valida(ev), .entrada_lista(el0),
      .binario0(a8[3:0]), .binario1(b8[3:0]), .modo(modo),
      .salida_valida(sv0), .salida_lista(sl), .suma(s0), .desborde(ds0),
      .operaciones(op0));

   sumador_acumulador #(.ANCHO(4), .ANCHO_SUMA(8), .SATURAR(1'b1)) dut1 (
      .clk(clk), .reset(reset), .entrada_valida(ev), .entrada_lista(el1),
      .binario0(a8[3:0]), .binario1(b8[3:0]), .modo(modo),
      .salida_valida(sv1), .salida_lista(sl), .suma(s1), .desborde(ds1),
      .operaciones(op1));

   sumador_acumulador #(.ANCHO(8), .ANCHO_SUMA(9), .SATURAR(1'b0)) dut2 (
      .clk(clk), .reset(reset), .entrada_valida(ev), .entrada_lista(el2),
      .binario0(a8), .binario1(b8), .modo(modo),
      .salida_valida(sv2), .salida_lista(sl), .suma(s2), .desborde(ds2),
      .operaciones(op2));

   typedef struct {
      string      name;
      logic [1:0] m;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] s0;
      logic       d0;
      logic [7:0] s1;
      logic       d1;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Issues one operation starting from a negedge. Returns at the negedge
   // where salida_valida is first seen high. lat counts the negedges after
   // the one that follows the accepting edge.
   task automatic op(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                     output int lat);
      int n;
      n = 0;
      while (el0 !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("entrada_lista_antes", el0, 1);
      modo = m;
      a8   = a;
      b8   = b;
      ev   = 1'b1;
      @(posedge clk);
      exp_ops++;
      @(negedge clk);
      ev  = 1'b0;
      lat = 0;
      while (sv0 !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("salida_valida_llega", sv0, 1);
      $display("op modo=%0d a=%0h b=%0h -> suma=%0h desborde=%0b ops=%0d",
               m, a, b, s0, ds0, op0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int n;
      logic [7:0] ea;
      logic [7:0] eb;

      tbl[0] = '{"add_A_5",   2'b00, 8'hA, 8'h5, 8'h0F, 1'b0, 8'h0F, 1'b0};
      tbl[1] = '{"sub_3_5",   2'b10, 8'h3, 8'h5, 8'hFE, 1'b1, 8'hFE, 1'b1};
      tbl[2] = '{"sub_9_4",   2'b10, 8'h9, 8'h4, 8'h05, 1'b0, 8'h05, 1'b0};
      tbl[3] = '{"add_0_0",   2'b00, 8'h0, 8'h0, 8'h00, 1'b0, 8'h00, 1'b0};
      tbl[4] = '{"sub_7_7",   2'b10, 8'h7, 8'h7, 8'h00, 1'b0, 8'h00, 1'b0};
      tbl[5] = '{"add_8_1",   2'b00, 8'h8, 8'h1, 8'h09, 1'b0, 8'h09, 1'b0};
      tbl[6] = '{"acc_5",     2'b01, 8'h5, 8'h0, 8'h05, 1'b0, 8'h05, 1'b0};
      tbl[7] = '{"acc_9_bF",  2'b01, 8'h9, 8'hF, 8'h0E, 1'b0, 8'h0E, 1'b0};
      tbl[8] = '{"sub_0_F",   2'b10, 8'h0, 8'hF, 8'hF1, 1'b1, 8'hF1, 1'b1};
      tbl[9] = '{"clear",     2'b11, 8'h7, 8'h7, 8'h00, 1'b0, 8'h00, 1'b0};

      reset = 1'b1; ev = 1'b0; sl = 1'b1; modo = 2'b00; a8 = 8'h0; b8 = 8'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_entrada_lista", el0, 1);
      chk("rst_salida_valida", sv0, 0);
      chk("rst_suma", s0, 0);
      chk("rst_desborde", ds0, 0);
      chk("rst_operaciones", op0, 0);
      reset = 1'b0;
      exp_ops = 0;

      // First add: latency, result, and ready returning one edge later
      op(2'b00, 8'hF, 8'hF, lat);
      chk("lat_add", lat, 1);
      chk("add_FF_suma", s0, 8'h1E);
      chk("add_FF_desborde", ds0, 0);
      chk("add_FF_ops", op0, 1);
      @(negedge clk);
      chk("lista_vuelve", el0, 1);
      chk("valida_cae", sv0, 0);

      // Table-driven vectors
      for (int i = 0; i < 10; i++) begin
         op(tbl[i].m, tbl[i].a, tbl[i].b, lat);
         chk({tbl[i].name, "_suma0"}, s0, tbl[i].s0);
         chk({tbl[i].name, "_desb0"}, ds0, tbl[i].d0);
         chk({tbl[i].name, "_suma1"}, s1, tbl[i].s1);
         chk({tbl[i].name, "_desb1"}, ds1, tbl[i].d1);
         chk({tbl[i].name, "_ops"}, op0, exp_ops & 255);
      end

      // Accumulate 15 eighteen times from zero: 17*15=255, 18*15=270
      for (int k = 1; k <= 18; k++) begin
         op(2'b01, 8'hF, 8'h3, lat);
         if (k == 17) begin
            chk("acc17_suma_wrap", s0, 8'hFF);
            chk("acc17_desb_wrap", ds0, 0);
            chk("acc17_suma_sat", s1, 8'hFF);
            chk("acc17_desb_sat", ds1, 0);
         end
         if (k == 18) begin
            chk("acc18_suma_wrap", s0, 8'h0E);
            chk("acc18_desb_wrap", ds0, 1);
            chk("acc18_suma_sat", s1, 8'hFF);
            chk("acc18_desb_sat", ds1, 1);
         end
      end
      op(2'b11, 8'h0, 8'h0, lat);
      chk("clear_suma_wrap", s0, 0);
      chk("clear_suma_sat", s1, 0);
      op(2'b01, 8'h1, 8'h0, lat);
      chk("acc1_tras_clear_wrap", s0, 1);
      chk("acc1_tras_clear_sat", s1, 1);

      // Backpressure: 2+3 held while entrada_valida stays high with new operands
      n = 0;
      while (el0 !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("bp_lista_inicial", el0, 1);
      sl = 1'b0; modo = 2'b00; a8 = 8'h2; b8 = 8'h3; ev = 1'b1;
      @(posedge clk);
      exp_ops++;
      @(negedge clk);
      a8 = 8'h7; b8 = 8'h1; modo = 2'b01;
      chk("bp_calculo_lista", el0, 0);
      @(negedge clk);
      chk("bp_valida", sv0, 1);
      for (int i = 0; i < 5; i++) begin
         chk("bp_suma_estable", s0, 5);
         chk("bp_lista_baja", el0, 0);
         chk("bp_valida_alta", sv0, 1);
         chk("bp_ops_fijo", op0, exp_ops & 255);
         @(negedge clk);
         a8 = 8'(i + 8); b8 = 8'(i + 1); modo = 2'(i);
      end
      a8 = 8'h6; b8 = 8'h1; modo = 2'b00; sl = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_handshake_valida", sv0, 0);
      chk("bp_handshake_lista", el0, 1);
      chk("bp_handshake_ops", op0, exp_ops & 255);
      @(posedge clk);
      exp_ops++;
      @(negedge clk);
      ev = 1'b0;
      chk("bp_reacepta_lista", el0, 0);
      @(negedge clk);
      chk("bp_segundo_valida", sv0, 1);
      chk("bp_segundo_suma", s0, 7);
      chk("bp_segundo_ops", op0, exp_ops & 255);

      // Reset during CALCULO of an accumulate once acc = 0x20
      op(2'b11, 8'h0, 8'h0, lat);
      op(2'b01, 8'hF, 8'h0, lat);
      op(2'b01, 8'hF, 8'h0, lat);
      op(2'b01, 8'h2, 8'h0, lat);
      chk("acc_20", s0, 8'h20);
      n = 0;
      while (el0 !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      modo = 2'b01; a8 = 8'h5; b8 = 8'h0; ev = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ev = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rstcalc_valida", sv0, 0);
      chk("rstcalc_suma", s0, 0);
      chk("rstcalc_ops", op0, 0);
      chk("rstcalc_lista", el0, 1);
      reset = 1'b0;
      exp_ops = 0;
      @(negedge clk);
      chk("rstcalc_sin_resultado", sv0, 0);
      op(2'b01, 8'h1, 8'h0, lat);
      chk("rstcalc_acc1", s0, 1);
      chk("rstcalc_ops1", op0, 1);

      // 256 back-to-back adds from reset: counter wraps to zero
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      exp_ops = 0;
      for (int i = 0; i < 256; i++) begin
         ea = 8'(i % 16);
         eb = 8'((i * 7) % 16);
         op(2'b00, ea, eb, lat);
         chk("wrap_add_suma", s0, ea + eb);
         if (i == 254) chk("ops_255", op0, 255);
      end
      chk("ops_wrap_0", op0, 0);

      // Width sweep on dut2 (ANCHO=8, ANCHO_SUMA=9)
      op(2'b00, 8'hFF, 8'hFF, lat);
      chk("sweep_add_suma", s2, 9'h1FE);
      chk("sweep_add_desb", ds2, 0);
      chk("sweep_add_suma_nibble", s0, 8'h1E);
      op(2'b10, 8'h10, 8'h20, lat);
      chk("sweep_sub_suma", s2, 9'h1F0);
      chk("sweep_sub_desb", ds2, 1);

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
